hash_state_acc: RTL and testbench
=================================

# hash_state_acc

Parametrised chaining-state accumulator for the SHA-256 miner datapath. It holds all WORDS chaining words H0..H(WORDS-1) and loads them from a parameter IV at message start. After each compressed block it adds the compressor's working variables into the state, serially at one word per clock to share a single WIDTH-bit adder. In double-hash mode it captures the first-pass digest, reloads the IV for the second pass, and flags the final digest.

## Interface
- WORDS, 8, number of chaining words (≥2)
- WIDTH, 32, bits per word
- IV, 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19, WORDS*WIDTH initial value; word 0 occupies the MSBs
- clk  in  1  sole clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin new message; sampled every cycle, any state
- double_mode  in  1  sampled only when start=1; 1 = two-pass hash
- add_valid  in  1  compressor result available
- add_ready  out  1  accumulator can accept a block result
- add_final  in  1  block is the last of the current pass; qualified by handshake
- add_data  in  WORDS*WIDTH  compressor outputs a..h, word i at bits [(WORDS-i)*WIDTH-1 -: WIDTH]
- h_state  out  WORDS*WIDTH  current chaining value for the compressor, same packing
- digest  out  WORDS*WIDTH  last completed pass result
- mid_valid  out  1  one-cycle pulse: first-pass digest of a double hash is on digest
- digest_valid  out  1  one-cycle pulse: final digest is on digest
- pass  out  1  0 = first pass, 1 = second pass
- blk_cnt  out  8  blocks accepted in current pass, saturates at 255
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, WAIT, ADD, FIN. The registered `dbl` bit holds the sampled double_mode; `fin` holds the handshaken add_final; `idx` is the word index, ceil(log2 WORDS) bits.
- Reset values: state=IDLE, h_state=IV, digest=0, mid_valid=0, digest_valid=0, pass=0, blk_cnt=0, idx=0, dbl=0, fin=0; add_ready=0 and busy=0 (both decoded from state).
- Priority: rst > start > all other activity.
- start: from any state, h_state←IV, pass←0, blk_cnt←0, idx←0, dbl←double_mode, state←WAIT. Any in-flight accumulation is discarded.
- add_ready=1 only in WAIT. Handshake = add_valid & add_ready. add_valid in other states is ignored and no data is lost from the accumulator's side; the source holds.
- On handshake: latch add_data into an internal buffer, fin←add_final, blk_cnt←sat(blk_cnt+1), idx←0, state←ADD.
- ADD: each cycle, word idx of h_state ← (h_state[idx] + buf[idx]) mod 2^WIDTH; carry is discarded and other words are untouched. idx increments; after idx=WORDS-1 the next state is WAIT if fin=0, else FIN.
- FIN (one cycle): digest←h_state.
  - If dbl=1 and pass=0: mid_valid←1, pass←1, blk_cnt←0, h_state←IV, state←WAIT.
  - Otherwise: digest_valid←1, state←IDLE.
- mid_valid and digest_valid are high for exactly one cycle, then cleared.
- digest holds its value until the next FIN or rst; start does not clear it.
- h_state is stable while in WAIT and IDLE, and changes only in ADD, on start, or in FIN.

## Timing
- Handshake at edge E. Word i is updated at edge E+1+i. State leaves ADD at edge E+WORDS.
- Non-final block: add_ready is high again in the cycle after E+WORDS, so the earliest next handshake is edge E+WORDS+1. Throughput is one block per WORDS+1 cycles.
- Final block: FIN is the cycle after E+WORDS. digest and the valid pulse update at edge E+WORDS+1 and are visible for one cycle.
- Double mode: after mid_valid, add_ready reasserts in the same cycle the pulse is visible.
- start and the handshake in the same cycle: start wins and the block is not accepted (add_ready was high, but the data is dropped). The source must re-present the block.
- rst asserted during ADD or FIN: no digest/valid update occurs, and all outputs return to their reset values on that edge.
- blk_cnt at 255 with a further handshake: it stays at 255, and accumulation proceeds normally.

## Test plan
- Reset, then start with double_mode=0, one block with add_data all zeros and add_final=1. Required: add_ready is low for 8 cycles after the handshake; digest = IV; digest_valid pulses at handshake edge +9; busy then drops.
- Wrap-around: a single final block with word1=0x44985180 and all other words 0. Required: digest word1 = 0x00000005 and the other words equal IV.
- Serial ordering: a block with word i = i+1. Sample h_state each cycle and require word i to change exactly at handshake edge +1+i.
- Double mode with 2 first-pass blocks (final on the second) followed by 1 second-pass block, all data 0x00000001 per word. Required:
  - mid_valid pulses with digest = IV+2 per word, pass→1, h_state = IV;
  - the final digest_valid pulses with digest = IV+1 per word;
  - blk_cnt reads 2 and then 1 across the two passes.
- start during ADD mid-accumulation. Required: h_state = IV on the next cycle, state WAIT, no valid pulse, and the earlier digest is retained.
- rst during FIN, and start coincident with add_valid in WAIT. Required:
  - the rst case produces no pulse and leaves all outputs at their reset values;
  - in the coincident case the block is not counted (blk_cnt=0) and h_state = IV.

Source files
------------

// File: rtl/hash_state_acc.sv
// Chaining-state accumulator for the SHA-256 miner datapath.
// Holds H0..H(WORDS-1), adds each block result serially through one adder.
module hash_state_acc #(
  parameter int WORDS = 8,
  parameter int WIDTH = 32,
  parameter logic [WORDS*WIDTH-1:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   double_mode,
  input  logic                   add_valid,
  output logic                   add_ready,
  input  logic                   add_final,
  input  logic [WORDS*WIDTH-1:0] add_data,
  output logic [WORDS*WIDTH-1:0] h_state,
  output logic [WORDS*WIDTH-1:0] digest,
  output logic                   mid_valid,
  output logic                   digest_valid,
  output logic                   pass,
  output logic [7:0]             blk_cnt,
  output logic                   busy
);

  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int N  = WORDS * WIDTH;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ADD,
    S_FIN
  } state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    h_q, h_d;
  logic [N-1:0]    buf_q, buf_d;
  logic [N-1:0]    dig_q, dig_d;
  logic            mid_q, mid_d;
  logic            dv_q, dv_d;
  logic            pass_q, pass_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            dbl_q, dbl_d;
  logic            fin_q, fin_d;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    buf_d   = buf_q;
    dig_d   = dig_q;
    mid_d   = 1'b0;
    dv_d    = 1'b0;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    dbl_d   = dbl_q;
    fin_d   = fin_q;
    if (start) begin
      // start drops any in-flight block, including one handshaken now
      h_d     = IV;
      pass_d  = 1'b0;
      cnt_d   = 8'd0;
      idx_d   = '0;
      dbl_d   = double_mode;
      state_d = S_WAIT;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_WAIT: begin
          if (add_valid) begin
            buf_d   = add_data;
            fin_d   = add_final;
            cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
            idx_d   = '0;
            state_d = S_ADD;
          end
        end
        S_ADD: begin
          for (int i = 0; i < WORDS; i++) begin
            if (idx_q == IW'(i)) begin
              h_d[(WORDS-1-i)*WIDTH +: WIDTH] =
                h_q[(WORDS-1-i)*WIDTH +: WIDTH] +
                buf_q[(WORDS-1-i)*WIDTH +: WIDTH];
            end
          end
          if (idx_q == IW'(WORDS-1)) begin
            idx_d   = '0;
            state_d = fin_q ? S_FIN : S_WAIT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        S_FIN: begin
          dig_d = h_q;
          if (dbl_q && !pass_q) begin
            mid_d   = 1'b1;
            pass_d  = 1'b1;
            cnt_d   = 8'd0;
            h_d     = IV;
            state_d = S_WAIT;
          end else begin
            dv_d    = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      h_q     <= IV;
      buf_q   <= '0;
      dig_q   <= '0;
      mid_q   <= 1'b0;
      dv_q    <= 1'b0;
      pass_q  <= 1'b0;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      dbl_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      buf_q   <= buf_d;
      dig_q   <= dig_d;
      mid_q   <= mid_d;
      dv_q    <= dv_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      dbl_q   <= dbl_d;
      fin_q   <= fin_d;
    end
  end

  assign add_ready    = (state_q == S_WAIT);
  assign busy         = (state_q != S_IDLE);
  assign h_state      = h_q;
  assign digest       = dig_q;
  assign mid_valid    = mid_q;
  assign digest_valid = dv_q;
  assign pass         = pass_q;
  assign blk_cnt      = cnt_q;

endmodule

// File: tb/tb_hash_state_acc.sv
// Randomised self-checking bench for hash_state_acc.
// Reference model: word-wise modular sums of IV and block data.
module tb_hash_state_acc;

  localparam logic [255:0] IVP =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         double_mode = 1'b0;
  logic         add_valid = 1'b0;
  logic         add_ready;
  logic         add_final = 1'b0;
  logic [255:0] add_data = '0;
  logic [255:0] h_state;
  logic [255:0] digest;
  logic         mid_valid;
  logic         digest_valid;
  logic         pass;
  logic [7:0]   blk_cnt;
  logic         busy;

  int pass_cnt = 0;
  int total = 0;
  logic [255:0] iv_v;
  logic [255:0] m_last;

  hash_state_acc dut (
    .clk(clk), .rst(rst), .start(start),
    .double_mode(double_mode),
    .add_valid(add_valid), .add_ready(add_ready),
    .add_final(add_final), .add_data(add_data),
    .h_state(h_state), .digest(digest),
    .mid_valid(mid_valid),
    .digest_valid(digest_valid),
    .pass(pass), .blk_cnt(blk_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] vadd(
    input logic [255:0] a, input logic [255:0] b);
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = a[i*32 +: 32] + b[i*32 +: 32];
    return r;
  endfunction

  function automatic logic [255:0] splat(input logic [31:0] w);
    return {8{w}};
  endfunction

  function automatic logic [255:0] rnd_blk();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic do_start(input logic dm);
    start = 1'b1;
    double_mode = dm;
    tick();
    start = 1'b0;
    double_mode = 1'b0;
  endtask

  task automatic send(input logic [255:0] d, input logic f,
                      output bit to);
    int n = 0;
    to = 0;
    while (!add_ready && n < 30) begin tick(); n++; end
    if (!add_ready) begin to = 1; return; end
    add_valid = 1'b1;
    add_data  = d;
    add_final = f;
    tick();
    add_valid = 1'b0;
    add_final = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({add_ready, busy, mid_valid, digest_valid, pass, blk_cnt}
        !== 13'd0)
      $display("FAIL reset_ctl: got %b want 0",
        {add_ready, busy, mid_valid, digest_valid, pass, blk_cnt});
    else pass_cnt++;
    total++;
    if (h_state !== iv_v || digest !== '0)
      $display("FAIL reset_data: h=%h d=%h", h_state, digest);
    else pass_cnt++;
  endtask

  task automatic test_zero_block();
    bit to;
    int n = 0;
    bit rdy_low = 1;
    do_start(1'b0);
    send('0, 1'b1, to);
    while (!digest_valid && n < 20) begin
      if (add_ready) rdy_low = 0;
      tick(); n++;
    end
    total++;
    if (to || n != 9 || !rdy_low)
      $display("FAIL zero_timing: to=%0d lat=%0d rdy_low=%0d want 9",
        to, n, rdy_low);
    else pass_cnt++;
    total++;
    if (digest !== iv_v)
      $display("FAIL zero_digest: got %h want %h", digest, iv_v);
    else pass_cnt++;
    m_last = iv_v;
    tick();
    total++;
    if (digest_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL zero_after: dv=%b busy=%b want 0 0",
        digest_valid, busy);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    bit to;
    int n = 0;
    logic [255:0] d = '0;
    logic [255:0] exp;
    d[6*32 +: 32] = 32'h44985180;
    exp = vadd(iv_v, d);
    do_start(1'b0);
    send(d, 1'b1, to);
    while (!digest_valid && n < 20) begin tick(); n++; end
    total++;
    if (to || !digest_valid || digest !== exp
        || digest[6*32 +: 32] !== 32'h5)
      $display("FAIL wrap: got %h want %h", digest, exp);
    else pass_cnt++;
    m_last = exp;
  endtask

  task automatic test_serial();
    bit to;
    logic [255:0] d;
    logic [255:0] exp;
    for (int i = 0; i < 8; i++) d[(7-i)*32 +: 32] = 32'(i + 1);
    do_start(1'b0);
    send(d, 1'b0, to);
    total++;
    if (to || h_state !== iv_v)
      $display("FAIL serial_e0: h=%h want %h", h_state, iv_v);
    else pass_cnt++;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp = iv_v;
      for (int i = 0; i < k; i++)
        exp[(7-i)*32 +: 32] = iv_v[(7-i)*32 +: 32] + 32'(i + 1);
      total++;
      if (h_state !== exp)
        $display("FAIL serial_e%0d: got %h want %h", k, h_state, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_double();
    bit to0, to1, to2;
    int n = 0;
    do_start(1'b1);
    send(splat(32'd1), 1'b0, to0);
    send(splat(32'd1), 1'b1, to1);
    total++;
    if (to0 || to1 || blk_cnt !== 8'd2)
      $display("FAIL dbl_cnt1: got %0d want 2", blk_cnt);
    else pass_cnt++;
    while (!mid_valid && n < 20) begin tick(); n++; end
    total++;
    if (!mid_valid || digest !== vadd(iv_v, splat(32'd2))
        || digest_valid !== 1'b0)
      $display("FAIL dbl_mid: mv=%b d=%h", mid_valid, digest);
    else pass_cnt++;
    total++;
    if (pass !== 1'b1 || h_state !== iv_v || add_ready !== 1'b1
        || blk_cnt !== 8'd0)
      $display("FAIL dbl_reload: pass=%b rdy=%b cnt=%0d h=%h",
        pass, add_ready, blk_cnt, h_state);
    else pass_cnt++;
    send(splat(32'd1), 1'b1, to2);
    total++;
    if (to2 || blk_cnt !== 8'd1)
      $display("FAIL dbl_cnt2: got %0d want 1", blk_cnt);
    else pass_cnt++;
    n = 0;
    while (!digest_valid && n < 20) begin tick(); n++; end
    total++;
    if (!digest_valid || digest !== vadd(iv_v, splat(32'd1)))
      $display("FAIL dbl_final: dv=%b d=%h", digest_valid, digest);
    else pass_cnt++;
    m_last = vadd(iv_v, splat(32'd1));
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      bit to;
      int n;
      logic dm = 1'($urandom_range(0, 1));
      int nb = $urandom_range(1, 3);
      logic [255:0] m = iv_v;
      logic [255:0] d;
      do_start(dm);
      for (int p = 0; p < (dm ? 2 : 1); p++) begin
        for (int b = 0; b < nb; b++) begin
          d = rnd_blk();
          m = vadd(m, d);
          send(d, b == nb - 1, to);
        end
        n = 0;
        while (!(p == 0 && dm ? mid_valid : digest_valid) && n < 20) begin
          tick(); n++;
        end
        total++;
        if (to || n != 9 || digest !== m)
          $display("FAIL rand_%0d_p%0d: lat=%0d got %h want %h",
            it, p, n, digest, m);
        else pass_cnt++;
        m_last = m;
        m = iv_v;
        nb = $urandom_range(1, 3);
      end
    end
  endtask

  task automatic test_start_in_add();
    bit to;
    bit pulse = 0;
    do_start(1'b0);
    send(rnd_blk(), 1'b1, to);
    tick(); tick(); tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    total++;
    if (to || h_state !== iv_v || add_ready !== 1'b1 || blk_cnt !== 8'd0)
      $display("FAIL abort_state: rdy=%b cnt=%0d h=%h",
        add_ready, blk_cnt, h_state);
    else pass_cnt++;
    for (int k = 0; k < 12; k++) begin
      if (mid_valid || digest_valid) pulse = 1;
      tick();
    end
    total++;
    if (pulse || digest !== m_last || h_state !== iv_v)
      $display("FAIL abort_hold: pulse=%0d d=%h want %h",
        pulse, digest, m_last);
    else pass_cnt++;
  endtask

  task automatic test_start_coincident();
    do_start(1'b0);
    start = 1'b1;
    add_valid = 1'b1;
    add_final = 1'b1;
    add_data = rnd_blk();
    tick();
    start = 1'b0;
    add_valid = 1'b0;
    add_final = 1'b0;
    tick(); tick(); tick();
    total++;
    if (blk_cnt !== 8'd0 || h_state !== iv_v || add_ready !== 1'b1)
      $display("FAIL coincide: cnt=%0d rdy=%b h=%h",
        blk_cnt, add_ready, h_state);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    bit to;
    bit any_to = 0;
    int n = 0;
    do_start(1'b0);
    for (int b = 0; b < 255; b++) begin
      send(splat(32'd1), 1'b0, to);
      any_to |= to;
    end
    total++;
    if (any_to || blk_cnt !== 8'd255)
      $display("FAIL sat_255: got %0d want 255", blk_cnt);
    else pass_cnt++;
    send(splat(32'd1), 1'b0, to);
    total++;
    if (to || blk_cnt !== 8'd255)
      $display("FAIL sat_hold: got %0d want 255", blk_cnt);
    else pass_cnt++;
    send(splat(32'd1), 1'b1, to);
    while (!digest_valid && n < 20) begin tick(); n++; end
    total++;
    if (to || !digest_valid || digest !== vadd(iv_v, splat(32'd257)))
      $display("FAIL sat_digest: got %h want %h",
        digest, vadd(iv_v, splat(32'd257)));
    else pass_cnt++;
    m_last = vadd(iv_v, splat(32'd257));
  endtask

  task automatic test_rst_fin();
    bit to;
    do_start(1'b1);
    send(rnd_blk(), 1'b1, to);
    for (int k = 0; k < 8; k++) tick();
    total++;
    if (to || busy !== 1'b1 || add_ready !== 1'b0 || digest !== m_last)
      $display("FAIL fin_pre: busy=%b rdy=%b", busy, add_ready);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({add_ready, busy, mid_valid, digest_valid, pass, blk_cnt}
        !== 13'd0 || h_state !== iv_v || digest !== '0)
      $display("FAIL rst_fin: ctl=%b d=%h h=%h",
        {add_ready, busy, mid_valid, digest_valid, pass, blk_cnt},
        digest, h_state);
    else pass_cnt++;
    tick();
    total++;
    if (mid_valid !== 1'b0 || digest_valid !== 1'b0 || digest !== '0)
      $display("FAIL rst_after: mv=%b dv=%b", mid_valid, digest_valid);
    else pass_cnt++;
  endtask

  initial begin
    iv_v = IVP;
    m_last = '0;
    test_reset();
    test_zero_block();
    test_wrap();
    test_serial();
    test_double();
    test_random();
    test_start_in_add();
    test_start_coincident();
    test_saturate();
    test_rst_fin();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
